// File: rtl/retry_lrsm_ctrl.sv
// Local Retry State Machine for the CXL link-layer retry path: issues RETRY.Req,
// times out waiting for RETRY.Ack, escalates to PHY reinit and finally aborts.
module retry_lrsm_ctrl #(
  parameter logic [4:0]  MAX_NUM_RETRY      = 5'd10,
  parameter logic [4:0]  MAX_NUM_PHY_REINIT = 5'd10,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter int unsigned TMR_W              = 11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_crc_error,
  input  logic       i_llrreq_sent,
  input  logic       i_retry_ack,
  input  logic       i_phy_reinit_done,
  input  logic [4:0] i_retry_num_phy_reinit,
  output logic [2:0] o_state,
  output logic       o_send_retry_req,
  output logic       o_phy_reinit_req,
  output logic       o_num_phy_reinit_inc_en,
  output logic       o_retry_done,
  output logic       o_retry_abort,
  output logic [4:0] o_num_retry
);

  typedef enum logic [2:0] {
    StNormal    = 3'd0,
    StLlrreq    = 3'd1,
    StLocalIdle = 3'd2,
    StPhyReinit = 3'd3,
    StAbort     = 3'd4
  } state_e;

  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [4:0]       num_retry_q;
  logic             inc_en_q;
  logic             retry_done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StNormal;
      tmr_q        <= '0;
      num_retry_q  <= '0;
      inc_en_q     <= 1'b0;
      retry_done_q <= 1'b0;
    end else begin
      inc_en_q     <= 1'b0;
      retry_done_q <= 1'b0;
      unique case (state_q)
        StNormal: begin
          if (i_crc_error) state_q <= StLlrreq;
        end
        StLlrreq: begin
          // Retry budget exhausted: abort only if the PHY-reinit budget is gone too.
          if (num_retry_q == MAX_NUM_RETRY &&
              i_retry_num_phy_reinit == MAX_NUM_PHY_REINIT) begin
            state_q <= StAbort;
          end else if (num_retry_q == MAX_NUM_RETRY) begin
            state_q     <= StPhyReinit;
            inc_en_q    <= 1'b1;
            num_retry_q <= '0;
          end else if (i_llrreq_sent) begin
            state_q     <= StLocalIdle;
            num_retry_q <= num_retry_q + 5'd1;
            tmr_q       <= '0;
          end
        end
        StLocalIdle: begin
          tmr_q <= tmr_q + TMR_W'(1);
          if (i_retry_ack) begin
            state_q      <= StNormal;
            num_retry_q  <= '0;
            retry_done_q <= 1'b1;
          end else if (tmr_q == TmrLast) begin
            state_q <= StLlrreq;
          end
        end
        StPhyReinit: begin
          if (i_phy_reinit_done) begin
            state_q     <= StLlrreq;
            num_retry_q <= '0;
          end
        end
        StAbort: state_q <= StAbort;
        default: state_q <= StNormal;
      endcase
    end
  end

  assign o_state                 = state_q;
  assign o_send_retry_req        = (state_q == StLlrreq);
  assign o_phy_reinit_req        = (state_q == StPhyReinit);
  assign o_retry_abort           = (state_q == StAbort);
  assign o_num_phy_reinit_inc_en = inc_en_q;
  assign o_retry_done            = retry_done_q;
  assign o_num_retry             = num_retry_q;

endmodule

// File: tb/tb_retry_lrsm_ctrl.sv
// Scoreboard bench for retry_lrsm_ctrl: a behavioural model queues expected outputs,
// a negedge monitor pops and compares them; directed scenarios plus random traffic.
module tb_retry_lrsm_ctrl;

  localparam int MaxRetry = 3;
  localparam int MaxPhy   = 10;
  localparam int Timeout  = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b0, crc = 1'b0, sent = 1'b0, ack = 1'b0, done = 1'b0;
  logic [4:0] cnt = 5'd0;
  logic [2:0] o_state;
  logic       o_send, o_phy, o_inc, o_done, o_abort;
  logic [4:0] o_num;

  int checks = 0;
  int errors = 0;

  retry_lrsm_ctrl #(
    .MAX_NUM_RETRY     (5'(MaxRetry)),
    .MAX_NUM_PHY_REINIT(5'(MaxPhy)),
    .TIMEOUT_CYCLES    (Timeout),
    .TMR_W             (11)
  ) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_crc_error            (crc),
    .i_llrreq_sent          (sent),
    .i_retry_ack            (ack),
    .i_phy_reinit_done      (done),
    .i_retry_num_phy_reinit (cnt),
    .o_state                (o_state),
    .o_send_retry_req       (o_send),
    .o_phy_reinit_req       (o_phy),
    .o_num_phy_reinit_inc_en(o_inc),
    .o_retry_done           (o_done),
    .o_retry_abort          (o_abort),
    .o_num_retry            (o_num)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the retry protocol, attempt count, cycles spent waiting.
  int m_phase = 0;
  int m_tries = 0;
  int m_waited = 0;
  bit m_inc = 0, m_done = 0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] pack(input int ph, input int tries, input bit inc,
                                       input bit dn);
    return {3'(ph), ph == 1, ph == 3, inc, dn, ph == 4, 5'(tries)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit s, input bit a, input bit d);
    rst = r; crc = c; sent = s; ack = a; done = d;
    m_inc = 0;
    m_done = 0;
    if (r) begin
      m_phase = 0; m_tries = 0; m_waited = 0;
    end else if (m_phase == 0) begin
      if (c) m_phase = 1;
    end else if (m_phase == 1) begin
      if (m_tries == MaxRetry && int'(cnt) == MaxPhy) m_phase = 4;
      else if (m_tries == MaxRetry) begin
        m_phase = 3; m_inc = 1; m_tries = 0;
      end else if (s) begin
        m_phase = 2; m_tries++; m_waited = 0;
      end
    end else if (m_phase == 2) begin
      if (a) begin
        m_phase = 0; m_tries = 0; m_done = 1;
      end else if (m_waited == Timeout - 1) m_phase = 1;
      m_waited++;
    end else if (m_phase == 3) begin
      if (d) begin
        m_phase = 1; m_tries = 0;
      end
    end
    exp_q.push_back(pack(m_phase, m_tries, m_inc, m_done));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int bound, output int n);
    n = 0;
    while (o_state != tgt && n < bound) begin
      idle();
      n++;
    end
    if (o_state != tgt) check("wait_state", int'(o_state), int'(tgt));
  endtask

  // One RETRY.Req sent from LLRREQ followed by a full timeout back to LLRREQ.
  task automatic round();
    int n;
    step(0, 0, 1, 0, 0);
    wait_state(3'd1, Timeout + 50, n);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e, a;
      e = exp_q.pop_front();
      a = {o_state, o_send, o_phy, o_inc, o_done, o_abort, o_num};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs actual=%h expected=%h at %0t", a, e, $time);
      end
    end
  end

  initial begin
    int n;
    int inc_seen;
    // Reset with every input asserted.
    cnt = 5'h1f;
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    cnt = 5'd0;
    idle();
    check("reset_state", int'(o_state), 0);
    check("reset_outputs", int'({o_send, o_phy, o_inc, o_done, o_abort, o_num}), 0);

    // Single retry acknowledged after 5 cycles.
    step(0, 1, 0, 0, 0);
    check("crc_to_llrreq", int'(o_state), 1);
    step(0, 0, 1, 0, 0);
    check("sent_num_retry", int'(o_num), 1);
    repeat (5) idle();
    step(0, 0, 0, 1, 0);
    check("ack_done_pulse", int'(o_done), 1);
    idle();
    check("done_one_cycle", int'(o_done), 0);

    // Timeout dwell and resend.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    wait_state(3'd1, 2000, n);
    check("timeout_dwell", n, Timeout);
    step(0, 0, 1, 0, 0);
    check("resend_num_retry", int'(o_num), 2);

    // Escalation to PHY reinit with the count input at 0.
    wait_state(3'd1, Timeout + 50, n);
    round();
    check("at_max_retry", int'(o_num), MaxRetry);
    idle();
    check("phy_reinit_entry", int'(o_state), 3);
    inc_seen = int'(o_inc);
    repeat (6) begin
      step(0, $urandom_range(0, 1), 0, $urandom_range(0, 1), 0);
      inc_seen += int'(o_inc);
      check("phy_req_level", int'(o_phy), 1);
    end
    check("inc_en_single", inc_seen, 1);
    step(0, 0, 0, 0, 1);
    check("reinit_done_llrreq", int'(o_state), 1);

    // Abort once both budgets are exhausted.
    repeat (MaxRetry) round();
    cnt = 5'(MaxPhy);
    idle();
    check("abort_entry", int'(o_state), 4);
    check("abort_no_inc", int'(o_inc), 0);
    repeat (100) step(0, $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1));
    check("abort_sticky", int'(o_abort), 1);
    step(1, 0, 0, 0, 0);
    check("abort_reset", int'(o_state), 0);
    cnt = 5'd0;

    // Ack on the final timeout cycle wins.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (Timeout - 1) idle();
    step(0, 0, 0, 1, 0);
    check("ack_at_timeout", int'(o_state), 0);

    // Reset in the middle of PHY reinit.
    step(0, 1, 0, 0, 0);
    repeat (MaxRetry) round();
    idle();
    repeat (3) idle();
    step(1, 0, 0, 0, 0);
    check("rst_mid_reinit", int'(o_state), 0);
    check("rst_mid_reinit_inc", int'(o_inc), 0);

    // Random traffic.
    for (int i = 0; i < 15000 && errors < 50; i++) begin
      cnt = ($urandom_range(0, 7) == 0) ? 5'(MaxPhy) : 5'($urandom_range(0, 31));
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
